// File: rtl/romulus_rho_stream.sv
// romulus_rho_stream: 128-bit Romulus state S with a handshaked rho datapath.
// One message block streams through S as BEATS beats of BUSW bits. Each beat
// works on the top BUSW bits of S, then S rotates left by BUSW, so the byte
// order is restored after a full pass. Partial blocks are padded by len.
module romulus_rho_stream #(
  parameter int BUSW   = 32,
  parameter bit PAD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [4:0]      len,
  input  logic            clr,
  input  logic            tbc_we,
  input  logic [127:0]    tbc_state,
  output logic [127:0]    state_o,
  input  logic [BUSW-1:0] pdi_data,
  input  logic            pdi_valid,
  output logic            pdi_ready,
  output logic [BUSW-1:0] pdo_data,
  output logic            pdo_valid,
  input  logic            pdo_ready,
  output logic            busy,
  output logic            done
);

  localparam int BEATS = 128 / BUSW;
  localparam int NB    = BUSW / 8;

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FLUSH = 2'b10} fsm_t;

  fsm_t            fsm_r;
  logic [127:0]    s_r;
  logic [3:0]      cnt_r;
  logic [1:0]      mode_r;
  logic [4:0]      len_r;
  logic [BUSW-1:0] pdo_data_r;
  logic            pdo_valid_r;
  logic            done_r;

  logic [4:0]      len_eff_s;
  logic [BUSW-1:0] top_s;
  logic [BUSW-1:0] m_s;
  logic [BUSW-1:0] out_s;
  logic [127:0]    next_s_s;
  logic            beat_fire_s;
  logic            last_beat_s;
  logic            pdi_ready_s;

  // Romulus G on one byte: shift right, new MSB = b0 ^ b7.
  function automatic logic [7:0] g_byte(input logic [7:0] b);
    return {b[0] ^ b[7], b[7:1]};
  endfunction

  assign state_o   = s_r;
  assign pdo_data  = pdo_data_r;
  assign pdo_valid = pdo_valid_r;
  assign busy      = (fsm_r != IDLE);
  assign done      = done_r;
  assign pdi_ready = pdi_ready_s;

  // Effective block length: padding off or an out-of-range len means full block.
  always_comb begin
    if (!PAD_EN || (len_r > 5'd16)) begin
      len_eff_s = 5'd16;
    end else begin
      len_eff_s = len_r;
    end
  end

  // Handshake qualifiers: a beat advances when its input and output sides can both move.
  always_comb begin
    pdi_ready_s = (fsm_r == RUN) && (mode_r != 2'b11) &&
                  ((mode_r == 2'b00) || !pdo_valid_r || pdo_ready);
    if (mode_r == 2'b11) begin
      beat_fire_s = (fsm_r == RUN) && (!pdo_valid_r || pdo_ready);
    end else begin
      beat_fire_s = pdi_valid && pdi_ready_s;
    end
    last_beat_s = (cnt_r == 4'(BEATS - 1));
  end

  // Per-byte rho datapath for the current beat, including padding and output masking.
  always_comb begin : rho_dp
    logic [7:0] idx;
    logic [7:0] pb;
    logic [7:0] gb;
    logic [7:0] src;
    logic [7:0] padb;
    logic [7:0] ob;
    logic       keep;
    idx   = 8'd0;
    pb    = 8'd0;
    gb    = 8'd0;
    src   = 8'd0;
    padb  = 8'd0;
    ob    = 8'd0;
    keep  = 1'b0;
    top_s = s_r[127 -: BUSW];
    m_s   = '0;
    out_s = '0;
    for (int j = 0; j < NB; j++) begin
      idx  = 8'(cnt_r) * 8'(NB) + 8'(j);
      pb   = pdi_data[BUSW-1-8*j -: 8];
      gb   = g_byte(top_s[BUSW-1-8*j -: 8]);
      keep = (idx < {3'b000, len_eff_s});
      if ((idx == 8'd15) && (len_eff_s < 5'd16)) begin
        padb = {3'b000, len_eff_s};
      end else begin
        padb = 8'd0;
      end
      if (mode_r == 2'b10) begin
        src = pb ^ gb;
      end else begin
        src = pb;
      end
      case (mode_r)
        2'b01:   ob = pb ^ gb;
        2'b10:   ob = src;
        2'b11:   ob = gb;
        default: ob = 8'd0;
      endcase
      if (mode_r == 2'b11) begin
        m_s[BUSW-1-8*j -: 8] = 8'd0;
      end else begin
        m_s[BUSW-1-8*j -: 8] = keep ? src : padb;
      end
      out_s[BUSW-1-8*j -: 8] = keep ? ob : 8'd0;
    end
    next_s_s = (s_r << BUSW) | 128'(top_s ^ m_s);
  end

  // Control FSM, state register S and registered pdo/done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r       <= IDLE;
      s_r         <= 128'd0;
      cnt_r       <= 4'd0;
      mode_r      <= 2'b00;
      len_r       <= 5'd0;
      pdo_data_r  <= '0;
      pdo_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (pdo_valid_r && pdo_ready) begin
        pdo_valid_r <= 1'b0;
      end
      case (fsm_r)
        IDLE: begin
          if (clr) begin
            s_r <= 128'd0;
          end else if (tbc_we) begin
            s_r <= tbc_state;
          end
          if (start) begin
            fsm_r  <= RUN;
            mode_r <= mode;
            len_r  <= len;
            cnt_r  <= 4'd0;
          end
        end
        RUN: begin
          if (beat_fire_s) begin
            s_r <= next_s_s;
            if (mode_r != 2'b00) begin
              pdo_data_r  <= out_s;
              pdo_valid_r <= 1'b1;
            end
            if (last_beat_s) begin
              cnt_r <= 4'd0;
              if (mode_r == 2'b00) begin
                fsm_r  <= IDLE;
                done_r <= 1'b1;
              end else begin
                fsm_r <= FLUSH;
              end
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end
        end
        FLUSH: begin
          if (pdo_valid_r && pdo_ready) begin
            fsm_r  <= IDLE;
            done_r <= 1'b1;
          end
        end
        default: fsm_r <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/romulus_rho_stream.md
Name: romulus_rho_stream

Overview:
- Parametrised, handshaked successor to the Romulus state/rho path.
- Holds the 128-bit Romulus state S and streams one 128-bit message block through it as 128/BUSW beats. Each beat applies rho (C = M ^ G(S), S ^= M) in absorb, encrypt, decrypt or squeeze mode.
- Adds valid/ready flow control, automatic padding of partial blocks and a TBC load/unload port.
- Sits between the pdi/pdo bus logic and the SKINNY round core.

Parameters:
- BUSW, 32, beat width in bits. Legal values: 8, 16, 32, 64, 128. Derived BEATS = 128/BUSW.
- PAD_EN, 1, 1 = pad partial blocks by len; 0 = len ignored and treated as 16.

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, reset. Asynchronous, active-low.
- start, input, 1, begin block pass; sampled in IDLE only.
- mode, input, 2, 00 absorb, 01 encrypt, 10 decrypt, 11 squeeze (output G(S)); latched on start.
- len, input, 5, valid bytes of this block, 0..16; latched on start.
- clr, input, 1, synchronous state clear; IDLE only.
- tbc_we, input, 1, load state from tbc_state; IDLE only; clr has priority.
- tbc_state, input, 128, TBC output.
- state_o, output, 128, current S. Byte 0 = bits [127:120].
- pdi_data, input, BUSW, input beat.
- pdi_valid, input, 1, input beat valid.
- pdi_ready, output, 1, input beat accepted when valid && ready.
- pdo_data, output, BUSW, output beat (registered).
- pdo_valid, output, 1, output beat valid.
- pdo_ready, input, 1, sink accepts output beat.
- busy, output, 1, FSM not in IDLE.
- done, output, 1, one-cycle pulse on return to IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): S = 0, FSM = IDLE, beat counter = 0, pdo_valid = 0, pdo_data = 0, done = 0, busy = 0. Reset mid-pass aborts the pass; no partial state is kept.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE -> RUN on start.
  - RUN -> FLUSH after the last beat when an output register is still pending.
  - RUN -> IDLE after the last beat in absorb mode, or when no output is pending.
  - FLUSH -> IDLE on the pdo handshake.
  - done asserts for one cycle on every entry to IDLE.
  - start while busy is ignored.
- Beat k (0..BEATS-1) operates on the top BUSW bits of S, i.e. block bytes k*BUSW/8 onward.
- After each beat, S rotates left by BUSW: {S[127-BUSW:0], new_top}. After BEATS beats, byte order is restored.
- G per byte b: {b[0]^b[7], b[7:1]}.
- Padding (PAD_EN = 1, len < 16):
  - Bytes with index >= len take M byte = 0.
  - Byte 15 takes M byte = len.
  - pdo bytes with index >= len are driven 0.
  - len = 16 means no padding.
- Per-beat rules:
  - absorb: S ^= M; no pdo.
  - encrypt: pdo = pdi ^ G(S); S ^= M, where M = padded pdi.
  - decrypt: M = padded(pdi ^ G(S)); pdo = M with bytes >= len = 0; S ^= M.
  - squeeze: no pdi consumed; pdo = G(S); S only rotates.
- Handshake:
  - pdi_ready = RUN && mode != 11 && (mode == 00 || !pdo_valid || pdo_ready).
  - In modes 01, 10 and 11, pdo_valid rises in the cycle after the beat is processed. A squeeze beat advances when !pdo_valid || pdo_ready.
  - pdo_data and pdo_valid are held stable while pdo_valid && !pdo_ready.
  - No beat is lost or duplicated.
- Beat counter wraps to 0 at the end of each pass. With BUSW = 128 the pass is a single beat.
- clr and tbc_we are ignored outside IDLE. clr and tbc_we in the same cycle: clr wins.
- state_o is the register S directly; no combinational path from pdi.

Test Plan (BUSW = 32):
- Absorb full block: after clr, absorb len = 16 with beats 00010203, 04050607, 08090A0B, 0C0D0E0F -> state_o = 000102030405060708090A0B0C0D0E0F; pdo_valid never rises; done pulses once.
- Encrypt: tbc_we with 01 repeated in all 16 bytes, encrypt len = 16 with zero beats -> four pdo beats of 80808080; state_o unchanged.
- Padding: absorb len = 5 with pdi all AA from S = 0 -> state_o = AAAAAAAAAA followed by 20 hex 0 then 05 (bytes 0-4 = AA, bytes 5-14 = 00, byte 15 = 05).
- Backpressure: encrypt with pdo_ready held low for 3 cycles mid-block -> pdi_ready low during the stall; pdo_data stable; four beats emitted in order; final S matches the no-stall run.
- Roundtrip: tbc_we with 02 in all 16 bytes, squeeze -> four pdo beats of 01010101. Then encrypt M, reload the same S, decrypt the resulting C -> pdo = M and identical final state_o.
- Async reset: drop rst_n mid-RUN after 2 beats -> busy, pdo_valid and state_o go to 0 with no clock edge; a subsequent start performs a full clean pass.
